// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single 32-bit memory port: grant, issue, wait for ack, respond.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention; the default is fixed priority to requester 0.
module mem_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we0,
    input  logic             req1,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             we1,
    output logic             sel,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a request; winner chosen and captured on exit
    // ISSUE | transaction presented to memory; watchdog counting
    // RESP  | dead cycle carrying the ACK/ERR pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic       last_served;
    logic       grant, done, timeout, pick;

    always_comb begin
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick = ~last_served;
`else
            pick = 1'b0;
`endif
        end else if (req1) begin
            pick = 1'b1;
        end else if (req0) begin
            pick = 1'b0;
        end else begin
            pick = last_served;  // no grant happens, value is a don't-care
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                // a late ack still wins over the watchdog in the same cycle
                if (mem_ack) begin
                    done       = 1'b1;
                    next_state = RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            rdata       <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            wait_cnt    <= 8'd0;
            last_served <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            if (grant) begin
                sel       <= pick;
                mem_req   <= 1'b1;
                mem_addr  <= pick ? addr1  : addr0;
                mem_wdata <= pick ? wdata1 : wdata0;
                mem_we    <= pick ? we1    : we0;
                wait_cnt  <= 8'd0;
            end
            if (state == ISSUE && !done && !timeout) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (done) begin
                rdata       <= mem_rdata;
                ack0        <= ~sel;
                ack1        <= sel;
                last_served <= sel;
                wait_cnt    <= 8'd0;
                mem_req     <= 1'b0;
            end
            if (timeout) begin
                err0        <= ~sel;
                err1        <= sel;
                last_served <= sel;
                wait_cnt    <= 8'd0;
                mem_req     <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences, randomized traffic.
// Build with ARB_ROUND_ROBIN_EN defined to check the round-robin variant.
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        sel, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata;
    logic        ack0, ack1, err0, err1, busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic        model_last;
    logic [31:0] model_rdata;

    typedef struct {
        logic        r0, r1;
        logic [31:0] a0, w0;
        logic        we0;
        logic [31:0] a1, w1;
        logic        we1;
        int          delay;
        logic [31:0] rd;
        logic        exp_sel;
        logic        exp_ack;
        int          exp_cycles;
    } vec_t;

    vec_t tbl[9];

    mem_port_arbiter #(.WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
        .sel(sel), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rdata(rdata),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r0, input logic r1,
                                input logic [31:0] a0, input logic [31:0] w0, input logic we0_i,
                                input logic [31:0] a1, input logic [31:0] w1, input logic we1_i,
                                input int delay, input logic [31:0] rd,
                                input logic exp_sel, input logic exp_ack, input int exp_cycles);
        vec_t v;
        v.r0 = r0; v.r1 = r1;
        v.a0 = a0; v.w0 = w0; v.we0 = we0_i;
        v.a1 = a1; v.w1 = w1; v.we1 = we1_i;
        v.delay = delay; v.rd = rd;
        v.exp_sel = exp_sel; v.exp_ack = exp_ack; v.exp_cycles = exp_cycles;
        return v;
    endfunction

    // Entered on a negedge with the arbiter idle; leaves on the negedge after it is idle again.
    task automatic run_txn(input vec_t v, input logic drop_req, input logic spur_ack);
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        int          cycles;
        e_addr  = v.exp_sel ? v.a1  : v.a0;
        e_wdata = v.exp_sel ? v.w1  : v.w0;
        e_we    = v.exp_sel ? v.we1 : v.we0;
        mem_ack = 1'b0;
        req0 = v.r0; req1 = v.r1;
        addr0 = v.a0; wdata0 = v.w0; we0 = v.we0;
        addr1 = v.a1; wdata1 = v.w1; we1 = v.we1;
        @(negedge clk);
        chk1("grant_busy", busy, 1'b1);
        chk1("grant_sel", sel, v.exp_sel);
        chk32("grant_wdata", mem_wdata, e_wdata);
        chk1("grant_we", mem_we, e_we);
        cycles = 0;
        while (mem_req === 1'b1 && cycles < MAX_WAIT + 2) begin
            chk32("issue_addr_held", mem_addr, e_addr);
            addr0 = $urandom; addr1 = $urandom;
            wdata0 = $urandom; wdata1 = $urandom;
            we0 = ~we0; we1 = ~we1;
            if (drop_req) begin req0 = 1'b0; req1 = 1'b0; end
            mem_ack   = (cycles == v.delay);
            mem_rdata = mem_ack ? v.rd : $urandom;
            cycles++;
            @(negedge clk);
        end
        if (v.exp_ack) model_rdata = v.rd;
        chk_int("issue_cycles", cycles, v.exp_cycles);
        chk1("resp_ack0", ack0, v.exp_ack & ~v.exp_sel);
        chk1("resp_ack1", ack1, v.exp_ack & v.exp_sel);
        chk1("resp_err0", err0, ~v.exp_ack & ~v.exp_sel);
        chk1("resp_err1", err1, ~v.exp_ack & v.exp_sel);
        chk32("resp_rdata", rdata, model_rdata);
        chk1("resp_busy", busy, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        mem_ack = spur_ack;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_pulses", ack0 | ack1 | err0 | err1, 1'b0);
        chk1("idle_sel_held", sel, v.exp_sel);
        chk32("idle_rdata", rdata, model_rdata);
        model_last = v.exp_sel;
    endtask

    initial begin
        logic [3:0] cont_order;
        vec_t       v;
        logic [1:0] r;
`ifdef ARB_ROUND_ROBIN_EN
        cont_order = 4'b1010;
`else
        cont_order = 4'b0000;
`endif
        tbl[0] = mk(1, 0, 32'h0000_1000, 32'h0, 0, 32'h0, 32'h0, 0, 2, 32'hDEAD_BEEF, 0, 1, 3);
        tbl[1] = mk(0, 1, 32'h0, 32'h0, 0, 32'h0000_2000, 32'h1234_5678, 1, 1, 32'h0BAD_F00D, 1, 1, 2);
        for (int i = 0; i < 4; i++)
            tbl[2+i] = mk(1, 1, 32'h100 + 32'(i), 32'hA000 + 32'(i), 0,
                          32'h200 + 32'(i), 32'hB000 + 32'(i), 1, 1, 32'hC000 + 32'(i),
                          cont_order[i], 1, 2);
        tbl[6] = mk(1, 0, 32'h0000_4000, 32'hAAAA_5555, 1, 32'h0, 32'h0, 0, 99, 32'h0, 0, 0, 4);
        tbl[7] = mk(1, 0, 32'h0000_5000, 32'h0, 0, 32'h0, 32'h0, 0, 3, 32'hCAFE_F00D, 0, 1, 4);
        tbl[8] = mk(0, 1, 32'h0, 32'h0, 0, 32'h0000_6000, 32'h5A5A_A5A5, 1, 5, 32'h0, 1, 0, 4);

        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        mem_ack = 0; mem_rdata = 0;
        model_last = 1'b1; model_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk1("rst_sel", sel, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_rdata", rdata, 32'h0);
        chk1("rst_pulses", ack0 | ack1 | err0 | err1, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_txn(tbl[i], 1'b0, 1'b0);

        // stray memory acks while idle must be ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        repeat (2) begin
            @(negedge clk);
            chk1("idle_ack_busy", busy, 1'b0);
            chk1("idle_ack_req", mem_req, 1'b0);
            chk1("idle_ack_pulses", ack0 | ack1 | err0 | err1, 1'b0);
            chk32("idle_ack_rdata", rdata, model_rdata);
        end
        mem_ack = 1'b0;

        // reset in the middle of an issue
        req1 = 1'b1; addr1 = 32'h0000_3000; wdata1 = 32'h3333_3333; we1 = 1'b1;
        @(negedge clk);
        chk1("mid_req", mem_req, 1'b1);
        chk1("mid_sel", sel, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_mem_req", mem_req, 1'b0);
        chk1("async_sel", sel, 1'b0);
        chk1("async_busy", busy, 1'b0);
        req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1; model_rdata = 32'h0;
        chk1("post_rst_pulses", ack0 | ack1 | err0 | err1, 1'b0);
        @(negedge clk);
        chk1("post_rst_pulses2", ack0 | ack1 | err0 | err1, 1'b0);
        chk1("post_rst_busy", busy, 1'b0);
        run_txn(mk(0, 1, 32'h0, 32'h0, 0, 32'h0000_7000, 32'h7777_7777, 0, 0, 32'h1357_9BDF, 1, 1, 1),
                1'b0, 1'b0);

        // randomized traffic against a transaction-level model
        for (int n = 0; n < 40; n++) begin
            r = 2'($urandom_range(1, 3));
            v.r0 = r[0]; v.r1 = r[1];
            v.a0 = $urandom; v.w0 = $urandom; v.we0 = 1'($urandom);
            v.a1 = $urandom; v.w1 = $urandom; v.we1 = 1'($urandom);
            v.delay = $urandom_range(0, MAX_WAIT + 1);
            v.rd = $urandom;
            if (v.r0 && v.r1) begin
`ifdef ARB_ROUND_ROBIN_EN
                v.exp_sel = ~model_last;
`else
                v.exp_sel = 1'b0;
`endif
            end else begin
                v.exp_sel = v.r1;
            end
            v.exp_ack    = (v.delay < MAX_WAIT);
            v.exp_cycles = v.exp_ack ? v.delay + 1 : MAX_WAIT;
            run_txn(v, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule
